// File: rtl/game_state_memory.sv
// Flip-flop game-state store: registered read port, priority-ordered writers, per-input
// change flags, combinational snapshot windows and a sequential clear sweep.
module game_state_memory #(
    parameter int SIZE        = 16,
    parameter int DEPTH       = 64,
    localparam int AW         = $clog2(DEPTH),
    parameter int NUM_INPUTS  = 2,
    parameter logic [NUM_INPUTS*AW-1:0] INPUT_ADDRS = {AW'(29), AW'(0)},
    parameter int NUM_REGIONS = 3,
    parameter int REGION_LEN  = 9,
    parameter logic [NUM_REGIONS*AW-1:0] REGION_STARTS = {AW'(19), AW'(10), AW'(1)},
    parameter int CLEAR_LO    = 1,
    parameter int CLEAR_HI    = 28
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [AW-1:0]                         waddr,
    input  logic [SIZE-1:0]                       write_data,
    input  logic                                  write_en,
    input  logic [AW-1:0]                         raddr,
    output logic [SIZE-1:0]                       read_data,
    input  logic [NUM_INPUTS*SIZE-1:0]            in_write_data,
    input  logic [NUM_INPUTS-1:0]                 in_write_en,
    output logic [NUM_INPUTS*SIZE-1:0]            in_read_data,
    output logic [NUM_INPUTS-1:0]                 in_changed,
    input  logic [NUM_INPUTS-1:0]                 in_ack,
    output logic [NUM_REGIONS*REGION_LEN*SIZE-1:0] region_read,
    input  logic                                  clear_req,
    output logic                                  busy,
    output logic                                  clear_done
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    logic [SIZE-1:0]       mem_q [DEPTH];
    logic [SIZE-1:0]       mem_d [DEPTH];
    logic [0:0]            state_q, state_d;
    logic [AW-1:0]         ptr_q, ptr_d;
    logic [SIZE-1:0]       read_data_q, read_data_d;
    logic [NUM_INPUTS-1:0] in_changed_q, in_changed_d;
    logic [NUM_INPUTS-1:0] in_accept;
    logic                  clear_done_q, clear_done_d;
    logic                  sweeping;

    function automatic logic in_range(input logic [AW-1:0] a);
        return 32'(a) < 32'(DEPTH);
    endfunction

    function automatic logic [AW-1:0] in_addr(input int i);
        return INPUT_ADDRS[i*AW +: AW];
    endfunction

    assign sweeping = (state_q == CLEAR);

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        clear_done_d = 1'b0;
        if (state_q == IDLE) begin
            if (clear_req) begin
                state_d = CLEAR;
                ptr_d   = AW'(CLEAR_LO);
            end
        end else begin
            ptr_d = ptr_q + AW'(1);
            if (ptr_q == AW'(CLEAR_HI)) begin
                state_d      = IDLE;
                ptr_d        = '0;
                clear_done_d = 1'b1;
            end
        end
    end

    // Writers applied lowest priority first so higher-priority writers overwrite them.
    always_comb begin
        mem_d = mem_q;
        for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
            if (in_write_en[i] && in_range(in_addr(i))) begin
                mem_d[in_addr(i)] = in_write_data[i*SIZE +: SIZE];
            end
        end
        if (write_en && !sweeping && in_range(waddr)) begin
            mem_d[waddr] = write_data;
        end
        if (sweeping && in_range(ptr_q)) begin
            mem_d[ptr_q] = '0;
        end
    end

    always_comb begin
        in_accept    = '0;
        in_changed_d = in_changed_q;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            in_accept[i] = in_write_en[i] && in_range(in_addr(i))
                           && !(sweeping && in_addr(i) == ptr_q)
                           && !(write_en && !sweeping && waddr == in_addr(i));
            for (int j = 0; j < i; j++) begin
                if (in_write_en[j] && in_addr(j) == in_addr(i)) begin
                    in_accept[i] = 1'b0;
                end
            end
            if (in_accept[i] && in_write_data[i*SIZE +: SIZE] != mem_q[in_addr(i)]) begin
                in_changed_d[i] = 1'b1;
            end else if (in_ack[i]) begin
                in_changed_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        int a;
        read_data_d  = in_range(raddr) ? mem_q[raddr] : '0;
        in_read_data = '0;
        region_read  = '0;
        a            = 0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (in_range(in_addr(i))) begin
                in_read_data[i*SIZE +: SIZE] = mem_q[in_addr(i)];
            end
        end
        for (int r = 0; r < NUM_REGIONS; r++) begin
            for (int k = 0; k < REGION_LEN; k++) begin
                a = int'(REGION_STARTS[r*AW +: AW]) + k;
                if (a < DEPTH) begin
                    region_read[(r*REGION_LEN+k)*SIZE +: SIZE] = mem_q[AW'(a)];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q        <= '{default: '0};
            state_q      <= IDLE;
            ptr_q        <= '0;
            read_data_q  <= '0;
            in_changed_q <= '0;
            clear_done_q <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            read_data_q  <= read_data_d;
            in_changed_q <= in_changed_d;
            clear_done_q <= clear_done_d;
        end
    end

    assign read_data  = read_data_q;
    assign in_changed = in_changed_q;
    assign busy       = sweeping;
    assign clear_done = clear_done_q;

endmodule

// File: tb/tb_game_state_memory.sv
// Bench for game_state_memory: directed vector table, hand-written sweep/reset sequences
// and random traffic compared against a behavioural model.
module tb_game_state_memory;

    localparam int SIZE = 16;
    localparam int AW   = 6;
    localparam int NR   = 3;
    localparam int RL   = 9;
    localparam int RW   = NR * RL * SIZE;
    localparam int CLO  = 1;
    localparam int CHI  = 28;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [AW-1:0]   waddr;
    logic [SIZE-1:0] write_data;
    logic            write_en;
    logic [AW-1:0]   raddr;
    logic [SIZE-1:0] read_data;
    logic [31:0]     in_write_data;
    logic [1:0]      in_write_en;
    logic [31:0]     in_read_data;
    logic [1:0]      in_changed;
    logic [1:0]      in_ack;
    logic [RW-1:0]   region_read;
    logic            clear_req;
    logic            busy;
    logic            clear_done;

    game_state_memory dut (
        .clk(clk), .rst_n(rst_n),
        .waddr(waddr), .write_data(write_data), .write_en(write_en),
        .raddr(raddr), .read_data(read_data),
        .in_write_data(in_write_data), .in_write_en(in_write_en),
        .in_read_data(in_read_data), .in_changed(in_changed), .in_ack(in_ack),
        .region_read(region_read),
        .clear_req(clear_req), .busy(busy), .clear_done(clear_done)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [15:0] m_mem [64];
    logic [15:0] m_read;
    logic [1:0]  m_changed;
    logic        m_done;
    int          m_sweep;
    int          in_addr_tb [2] = '{0, 29};
    int          starts [3] = '{1, 10, 19};

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [5:0]  waddr;
        logic [15:0] wdata;
        logic        we;
        logic [5:0]  raddr;
        logic [31:0] in_wd;
        logic [1:0]  in_we;
        logic [1:0]  ack;
        logic        clr;
        logic [15:0] exp_read;
        logic [1:0]  exp_changed;
        logic        exp_busy;
    } vec_t;

    vec_t vecs [10];

    task automatic model_reset();
        for (int a = 0; a < 64; a++) m_mem[a] = '0;
        m_read    = '0;
        m_changed = '0;
        m_done    = 1'b0;
        m_sweep   = -1;
    endtask

    // Each address is claimed by the first writer in priority order; later writers lose it.
    task automatic model_edge();
        logic [15:0] nxt [64];
        bit          claimed [64];
        bit          busy_now;
        busy_now = (m_sweep >= 0);
        for (int a = 0; a < 64; a++) begin
            nxt[a]     = m_mem[a];
            claimed[a] = 1'b0;
        end
        m_read = m_mem[raddr];
        if (busy_now) begin
            nxt[6'(m_sweep)]     = '0;
            claimed[6'(m_sweep)] = 1'b1;
        end
        if (write_en && !busy_now) begin
            nxt[waddr]     = write_data;
            claimed[waddr] = 1'b1;
        end
        for (int i = 0; i < 2; i++) begin
            if (in_write_en[i] && !claimed[in_addr_tb[i]]) begin
                claimed[in_addr_tb[i]] = 1'b1;
                nxt[in_addr_tb[i]]     = in_write_data[i*16 +: 16];
                if (in_write_data[i*16 +: 16] != m_mem[in_addr_tb[i]]) m_changed[i] = 1'b1;
                else if (in_ack[i]) m_changed[i] = 1'b0;
            end else if (in_ack[i]) begin
                m_changed[i] = 1'b0;
            end
        end
        m_done = 1'b0;
        if (busy_now) begin
            if (m_sweep == CHI) begin
                m_sweep = -1;
                m_done  = 1'b1;
            end else begin
                m_sweep++;
            end
        end else if (clear_req) begin
            m_sweep = CLO;
        end
        for (int a = 0; a < 64; a++) m_mem[a] = nxt[a];
    endtask

    task automatic check_output(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [RW-1:0] exp_reg;
        exp_reg = '0;
        for (int r = 0; r < NR; r++)
            for (int k = 0; k < RL; k++)
                exp_reg[(r*RL+k)*SIZE +: SIZE] = m_mem[starts[r]+k];
        check_output({tag, ".read_data"}, RW'(read_data), RW'(m_read));
        check_output({tag, ".busy"}, RW'(busy), RW'(m_sweep >= 0));
        check_output({tag, ".clear_done"}, RW'(clear_done), RW'(m_done));
        check_output({tag, ".in_changed"}, RW'(in_changed), RW'(m_changed));
        check_output({tag, ".in_read_data"}, RW'(in_read_data), RW'({m_mem[29], m_mem[0]}));
        check_output({tag, ".region_read"}, region_read, exp_reg);
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic apply_stimulus(input vec_t v);
        waddr         = v.waddr;
        write_data    = v.wdata;
        write_en      = v.we;
        raddr         = v.raddr;
        in_write_data = v.in_wd;
        in_write_en   = v.in_we;
        in_ack        = v.ack;
        clear_req     = v.clr;
    endtask

    task automatic idle_inputs();
        write_en    = 1'b0;
        in_write_en = '0;
        in_ack      = '0;
        clear_req   = 1'b0;
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;
        //           waddr  wdata     we    raddr  in_wd                 in_we  ack    clr   exp_read  chg    busy
        vecs[0] = '{6'd5,  16'hABCD, 1'b1, 6'd0,  32'h0,                2'b00, 2'b00, 1'b0, 16'h0000, 2'b00, 1'b0};
        vecs[1] = '{6'd0,  16'h0,    1'b0, 6'd5,  32'h0,                2'b00, 2'b00, 1'b0, 16'hABCD, 2'b00, 1'b0};
        vecs[2] = '{6'd0,  16'h1111, 1'b1, 6'd5,  {16'h0, 16'h2222},    2'b01, 2'b00, 1'b0, 16'hABCD, 2'b00, 1'b0};
        vecs[3] = '{6'd0,  16'h0,    1'b0, 6'd0,  {16'h0003, 16'h0},    2'b10, 2'b00, 1'b0, 16'h1111, 2'b10, 1'b0};
        vecs[4] = '{6'd0,  16'h0,    1'b0, 6'd29, {16'h0004, 16'h0},    2'b10, 2'b10, 1'b0, 16'h0003, 2'b10, 1'b0};
        vecs[5] = '{6'd0,  16'h0,    1'b0, 6'd29, 32'h0,                2'b00, 2'b10, 1'b0, 16'h0004, 2'b00, 1'b0};
        vecs[6] = '{6'd0,  16'h0,    1'b0, 6'd29, {16'h0004, 16'h0},    2'b10, 2'b00, 1'b0, 16'h0004, 2'b00, 1'b0};
        vecs[7] = '{6'd63, 16'h1234, 1'b1, 6'd0,  {16'h0, 16'h2222},    2'b01, 2'b00, 1'b0, 16'h1111, 2'b01, 1'b0};
        vecs[8] = '{6'd0,  16'h0,    1'b0, 6'd63, 32'h0,                2'b00, 2'b01, 1'b0, 16'h1234, 2'b00, 1'b0};
        vecs[9] = '{6'd0,  16'h0,    1'b0, 6'd0,  32'h0,                2'b00, 2'b00, 1'b0, 16'h2222, 2'b00, 1'b0};

        waddr = '0; write_data = '0; raddr = '0; in_write_data = '0;
        idle_inputs();
        model_reset();
        @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[v]) begin
            apply_stimulus(vecs[v]);
            tick($sformatf("vec%0d", v));
            check_output($sformatf("vec%0d.tbl_read", v), RW'(read_data), RW'(vecs[v].exp_read));
            check_output($sformatf("vec%0d.tbl_changed", v), RW'(in_changed), RW'(vecs[v].exp_changed));
            check_output($sformatf("vec%0d.tbl_busy", v), RW'(busy), RW'(vecs[v].exp_busy));
        end
        idle_inputs();
        check_output("window0_word4", RW'(region_read[4*SIZE +: SIZE]), RW'(16'hABCD));

        for (int a = CLO; a <= CHI; a++) begin
            waddr = 6'(a); write_data = 16'hFFFF; write_en = 1'b1;
            tick("fill");
        end
        write_en  = 1'b0;
        clear_req = 1'b1;
        tick("sweep_start");
        busy_cnt = busy ? 1 : 0;
        done_cnt = 0;
        waddr = 6'd3; write_data = 16'h5555; write_en = 1'b1;
        for (int c = 0; c < 35; c++) begin
            clear_req = (c == 10);
            tick("sweep");
            if (busy) busy_cnt++;
            if (clear_done) done_cnt++;
            if (!busy) write_en = 1'b0;
        end
        idle_inputs();
        check_output("sweep_busy_cycles", RW'(busy_cnt), RW'(28));
        check_output("sweep_done_pulses", RW'(done_cnt), RW'(1));
        check_output("sweep_region_zero", region_read, '0);
        check_output("sweep_keep_0_29", RW'(in_read_data), RW'({16'h0004, 16'h2222}));
        raddr = 6'd28;
        tick("sweep_last");
        check_output("sweep_word28", RW'(read_data), RW'(0));

        waddr = 6'd2; write_data = 16'h0202; write_en = 1'b1;
        tick("pre_rst_a");
        waddr = 6'd30; write_data = 16'h3030;
        tick("pre_rst_b");
        write_en  = 1'b0;
        clear_req = 1'b1;
        tick("rst_sweep_start");
        clear_req = 1'b0;
        for (int c = 0; c < 9; c++) tick("rst_sweep");
        rst_n = 1'b0;
        #2;
        model_reset();
        check_output("async_busy", RW'(busy), RW'(0));
        check_output("async_done", RW'(clear_done), RW'(0));
        check_output("async_region", region_read, '0);
        check_output("async_inputs", RW'(in_read_data), RW'(0));
        check_output("async_read", RW'(read_data), RW'(0));
        check_output("async_changed", RW'(in_changed), RW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        waddr = 6'd7; write_data = 16'h7777; write_en = 1'b1; raddr = 6'd30;
        tick("post_rst");
        check_output("post_rst_word30", RW'(read_data), RW'(0));
        write_en = 1'b0; raddr = 6'd7;
        tick("post_rst_rd");
        check_output("post_rst_word7", RW'(read_data), RW'(16'h7777));

        for (int n = 0; n < 400; n++) begin
            waddr = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 6'd0 : 6'd29)
                                                : 6'($urandom_range(0, 63));
            write_data    = 16'($urandom_range(0, 3));
            write_en      = ($urandom_range(0, 2) == 0);
            raddr         = 6'($urandom_range(0, 63));
            in_write_data = {16'($urandom_range(0, 3)), 16'($urandom_range(0, 3))};
            in_write_en   = 2'($urandom_range(0, 3));
            in_ack        = 2'($urandom_range(0, 3));
            clear_req     = ($urandom_range(0, 39) == 0);
            tick("rand");
        end
        idle_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/game_state_memory.md
GAME_STATE_MEMORY -- requirements
Module: game_state_memory

Interface
REQ-001 SHALL have parameter SIZE, default 16, word width in bits.
REQ-002 SHALL have parameter DEPTH, default 64, number of words; AW = $clog2(DEPTH).
REQ-003 SHALL have parameter NUM_INPUTS, default 2, number of dedicated input write channels.
REQ-004 SHALL have parameter INPUT_ADDRS, default {AW'd29, AW'd0}, packed NUM_INPUTS*AW target addresses, channel 0 in the LSBs.
REQ-005 SHALL have parameter NUM_REGIONS, default 3, number of snapshot windows.
REQ-006 SHALL have parameter REGION_LEN, default 9, words per window.
REQ-007 SHALL have parameter REGION_STARTS, default {AW'd19, AW'd10, AW'd1}, packed NUM_REGIONS*AW window base addresses.
REQ-008 SHALL have parameters CLEAR_LO, default 1, and CLEAR_HI, default 28, the inclusive clear-sweep bounds.
REQ-009 Ports, in order:
  clk  in  1  clock, all state on rising edge
  rst_n  in  1  reset
  waddr  in  AW  regular write address
  write_data  in  SIZE  regular write data
  write_en  in  1  regular write strobe
  raddr  in  AW  registered-read address
  read_data  out  SIZE  read result, one cycle after raddr
  in_write_data  in  NUM_INPUTS*SIZE  channel data, channel i at [i*SIZE +: SIZE]
  in_write_en  in  NUM_INPUTS  per-channel write strobes
  in_read_data  out  NUM_INPUTS*SIZE  current value at each INPUT_ADDRS entry
  in_changed  out  NUM_INPUTS  sticky per-channel value-changed flags
  in_ack  in  NUM_INPUTS  per-channel flag clears
  region_read  out  NUM_REGIONS*REGION_LEN*SIZE  window r word k at [(r*REGION_LEN+k)*SIZE +: SIZE]
  clear_req  in  1  start clear sweep
  busy  out  1  sweep in progress
  clear_done  out  1  one-cycle pulse at sweep end
REQ-010 One clock; reset is asynchronous and active-low.

Function
REQ-011 Storage SHALL be DEPTH x SIZE flip-flops.
REQ-012 in_read_data and region_read SHALL be combinational views of current storage.
REQ-013 read_data SHALL equal mem[raddr] sampled at the previous rising edge; a same-edge write returns the old value.
REQ-014 Write priority per address per edge SHALL be: sweep, then regular write, then input channel with the lowest index; lower-priority writes to the same address are dropped.
REQ-015 Writes to different addresses on the same edge SHALL all take effect.
REQ-016 The FSM SHALL have two states, IDLE and CLEAR; in IDLE with clear_req=1 it SHALL move to CLEAR with ptr=CLEAR_LO.
REQ-017 In CLEAR, each cycle SHALL write 0 to mem[ptr] and increment ptr; when ptr==CLEAR_HI, after writing it SHALL return to IDLE and pulse clear_done for one cycle.
REQ-018 A sweep SHALL take CLEAR_HI-CLEAR_LO+1 cycles; busy=1 exactly while in CLEAR.
REQ-019 While busy, write_en SHALL be ignored entirely, input writes SHALL still apply except at the current ptr, and clear_req SHALL be ignored.
REQ-020 in_changed[i] SHALL set on the edge where channel i's write is accepted and its data differs from the stored value.
REQ-021 in_changed[i] SHALL clear on in_ack[i]; set wins over a simultaneous ack.
REQ-022 Out-of-range addresses (>= DEPTH) SHALL write nothing and read 0.

Reset
REQ-023 While rst_n=0, all memory words, read_data, in_changed, busy, clear_done and ptr SHALL be 0, and the FSM SHALL be IDLE.
REQ-024 Reset mid-sweep SHALL abort the sweep with no clear_done pulse.
REQ-025 The first edge after rst_n rises SHALL process inputs normally.

Verification
REQ-026 Write waddr=5, data=0xABCD; next cycle raddr=5 -> read_data=0xABCD one cycle later; region_read word 4 of window 0 = 0xABCD.
REQ-027 Same edge: write_en with waddr=0, data=0x1111, and in_write_en[0] with data 0x2222 -> mem[0]=0x1111; in_changed[0] stays 0.
REQ-028 in_write_en[1] with 0x0003 while mem[29]=0 -> in_changed[1]=1; in_ack[1] asserted together with another differing write -> flag stays 1.
REQ-029 Fill 1..28 with 0xFFFF, pulse clear_req -> busy for 28 cycles, one clear_done pulse, words 1..28 = 0, words 0 and 29 unchanged; write_en during the sweep is dropped.
REQ-030 Drop rst_n 10 cycles into a sweep -> busy=0, no clear_done, all words 0, asynchronously, before the next edge.
